// File: rtl/mips_multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, stalling on the memory ready handshake.
module mips_multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADR   = 4'd3,
        MEM_RD    = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WR    = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        BEQ       = 4'd9,
        JUMP      = 4'd10,
        ADDI_EXEC = 4'd11,
        ADDI_WB   = 4'd12
    } state_t;

    state_t cur, nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = FETCH;
        case (cur)
            IDLE:      nxt = FETCH;
            FETCH:     nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = MEM_ADR;
                    OP_RTYPE:     nxt = R_EXEC;
                    OP_BEQ:       nxt = BEQ;
                    OP_J:         nxt = JUMP;
                    OP_ADDI:      nxt = ADDI_EXEC;
                    default:      nxt = FETCH;
                endcase
            end
            MEM_ADR:   nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:    nxt = mem_ready ? MEM_WB : MEM_RD;
            MEM_WR:    nxt = mem_ready ? FETCH : MEM_WR;
            R_EXEC:    nxt = R_WB;
            ADDI_EXEC: nxt = ADDI_WB;
            default:   nxt = FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        case (cur)
            FETCH: begin
                // IR and PC load only on the cycle the memory delivers the word
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                    default:                                       illegal_op = 1'b1;
                endcase
            end
            MEM_ADR, ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            ADDI_WB: reg_write = 1'b1;
            default: ;
        endcase
    end

    assign state = cur;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed sequences with literal expectations,
// then random opcode/mem_ready traffic checked every cycle against a route-table model.
module tb_mips_multicycle_ctrl;

    logic       clk, rst_n, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [16:0] dut_o;

    int checks = 0;
    int failures = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );

    // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,
    //  reg_dst,reg_write,alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_source[1:0],illegal_op}
    assign dut_o = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Moore outputs per state code, straight from the state descriptions
    logic [16:0] otab [0:12];
    initial begin
        otab[0]  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
        otab[1]  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
        otab[2]  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
        otab[3]  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
        otab[4]  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
        otab[5]  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
        otab[6]  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
        otab[7]  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
        otab[8]  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
        otab[9]  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
        otab[10] = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
        otab[11] = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
        otab[12] = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    end

    function automatic bit legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    endfunction

    // Model: each instruction is a route of state codes walked after FETCH;
    // FETCH, MEM_RD and MEM_WR repeat until mem_ready.
    int m_st = 0;
    int route[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0;
            route.delete();
        end else if (m_st == 0) begin
            m_st = 1;
        end else if ((m_st == 1 || m_st == 4 || m_st == 6) && !mem_ready) begin
            m_st = m_st;
        end else begin
            if (m_st == 1) begin
                case (opcode)
                    6'b100011: route = '{2, 3, 4, 5};
                    6'b101011: route = '{2, 3, 6};
                    6'b000000: route = '{2, 7, 8};
                    6'b000100: route = '{2, 9};
                    6'b000010: route = '{2, 10};
                    6'b001000: route = '{2, 11, 12};
                    default:   route = '{2};
                endcase
            end
            if (route.size() > 0) m_st = route.pop_front();
            else                  m_st = 1;
        end
    end

    always @(negedge clk) begin
        logic [16:0] exp_o;
        #2;
        exp_o = otab[m_st];
        if (m_st == 1 && mem_ready) exp_o = exp_o | 17'h10800;
        if (m_st == 2 && !legal(opcode)) exp_o = exp_o | 17'h00001;
        check("model_state", {28'b0, state}, m_st);
        check("model_outs", {15'b0, dut_o}, {15'b0, exp_o});
        check("mutex_mem", {31'b0, mem_read & mem_write}, 0);
        check("mutex_pc", {31'b0, pc_write & pc_write_cond}, 0);
    end

    task automatic run(input logic [5:0] opc, input logic [15:0] rdy, input int n,
                       input logic [31:0] exp_st, input int ci, input logic [16:0] cv,
                       output int n_mr, output int n_mw, output int n_rw, output int n_irw);
        n_mr = 0; n_mw = 0; n_rw = 0; n_irw = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_ready = rdy[i];
            opcode = opc;
            #1;
            check($sformatf("seq_state_%0d", i), {28'b0, state}, {28'b0, exp_st[4*i +: 4]});
            if (i == ci) check("seq_outs", {15'b0, dut_o}, {15'b0, cv});
            n_mr  += int'(mem_read);
            n_mw  += int'(mem_write);
            n_rw  += int'(reg_write);
            n_irw += int'(ir_write);
        end
    endtask

    initial begin
        int mr, mw, rw, irw;
        logic [5:0] ops [0:5];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b100011;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", {28'b0, state}, 0);
        check("reset_outs", {15'b0, dut_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_idle", {28'b0, state}, 0);

        // LW, ready throughout: 1,2,3,4,5 then held in FETCH
        run(6'b100011, 16'h001F, 6, 32'h00154321, 4, 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0, mr, mw, rw, irw);
        check("lw_reg_write_cnt", rw, 1);
        // SW with 3 stall cycles in MEM_WR
        run(6'b101011, 16'h0047, 8, 32'h16666321, 3, 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0, mr, mw, rw, irw);
        check("sw_mem_write_cnt", mw, 4);
        check("sw_reg_write_cnt", rw, 0);
        // BEQ then J
        run(6'b000100, 16'h0007, 3, 32'h00000921, 2, 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0, mr, mw, rw, irw);
        run(6'b000010, 16'h0007, 4, 32'h00001A21, 2, 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0, mr, mw, rw, irw);
        // FETCH stalled 2 cycles, then ADDI
        run(6'b001000, 16'h003C, 7, 32'h01CB2111, 2, 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0, mr, mw, rw, irw);
        check("fetch_stall_mem_read_cnt", mr, 4);
        check("fetch_stall_ir_write_cnt", irw, 1);
        // Illegal opcode
        run(6'b111111, 16'h0003, 3, 32'h00000121, 1, 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1, mr, mw, rw, irw);
        // Reset mid MEM_RD
        run(6'b100011, 16'h0007, 4, 32'h00004321, 3, 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0, mr, mw, rw, irw);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_state", {28'b0, state}, 0);
        check("midreset_mem_read", {31'b0, mem_read}, 0);
        check("midreset_outs", {15'b0, dut_o}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            mem_ready = ($urandom % 4) != 0;
            if (m_st == 1) begin
                int k;
                k = $urandom_range(0, 6);
                if (k < 6) opcode = ops[k];
                else       opcode = 6'($urandom % 64);
            end
        end

        @(negedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
